// File: rtl/rgbled_ctrl.sv
// Frame sequencer for the WS281x LED chain: holds one {R,G,B} register per LED and streams a frame to ws281x_drv.
// Optional autorefresh is enabled by defining RGBLED_CTRL_AUTOREFRESH_EN.
module rgbled_ctrl #(
   parameter int NumLeds       = 2,
   parameter int RefreshPeriod = 1_000_000,
   localparam int IdxW         = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            set_i,
   input  logic [IdxW-1:0] set_idx_i,
   input  logic [23:0]     set_rgb_i,
   input  logic            refresh_i,
   input  logic            off_i,
   output logic            busy_o,
   output logic            go_o,
   output logic [23:0]     data_o,
   output logic            data_valid_o,
   output logic            data_last_o,
   input  logic            data_ack_i,
   input  logic            idle_i
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_IDLE} state_e;

   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [23:0]     data_q, data_d;
   logic            last_q, last_d;
   logic            pending_q, pending_d;
   logic            load;
   logic [IdxW-1:0] load_idx;
   logic [23:0]     load_rgb;
   logic            tick;
   logic [23:0]     rgb_q [NumLeds];

   // The driver expects green first on the wire.
   function automatic logic [23:0] to_grb(input logic [23:0] rgb);
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
   endfunction

`ifdef RGBLED_CTRL_AUTOREFRESH_EN
   localparam int CntW = (RefreshPeriod > 1) ? $clog2(RefreshPeriod) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(RefreshPeriod - 1);

   logic [CntW-1:0] refresh_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || refresh_cnt_q == CntLast) refresh_cnt_q <= '0;
      else                                   refresh_cnt_q <= refresh_cnt_q + CntW'(1);
   end

   assign tick = (refresh_cnt_q == CntLast);
`else
   logic unused_refresh_period;

   assign unused_refresh_period = ^32'(RefreshPeriod);
   assign tick = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i || off_i) begin
         for (int i = 0; i < NumLeds; i++) rgb_q[i] <= '0;
      end else if (set_i) begin
         for (int i = 0; i < NumLeds; i++) begin
            if (set_idx_i == IdxW'(i)) rgb_q[i] <= set_rgb_i;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      last_d    = last_q;
      pending_d = pending_q | refresh_i | off_i | tick;
      load      = 1'b0;
      load_idx  = '0;
      load_rgb  = '0;
      unique case (state_q)
         IDLE: begin
            if ((pending_q || refresh_i || off_i) && idle_i) begin
               state_d   = SEND;
               idx_d     = '0;
               pending_d = 1'b0;
               load      = 1'b1;
            end
         end
         SEND: begin
            if (data_ack_i) begin
               if (idx_q == LastIdx) begin
                  state_d = WAIT_IDLE;
                  last_d  = 1'b0;
               end else begin
                  idx_d    = idx_q + IdxW'(1);
                  load     = 1'b1;
                  load_idx = idx_q + IdxW'(1);
               end
            end
         end
         WAIT_IDLE: begin
            if (idle_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Same-cycle clear or write to the word being loaded is forwarded.
      if (load) begin
         if (off_i)                               load_rgb = '0;
         else if (set_i && set_idx_i == load_idx) load_rgb = set_rgb_i;
         else                                     load_rgb = rgb_q[load_idx];
         data_d = to_grb(load_rgb);
         last_d = (load_idx == LastIdx);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         last_q    <= last_d;
         pending_q <= pending_d;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign go_o         = (state_q == SEND);
   assign data_valid_o = (state_q == SEND);
   assign data_last_o  = last_q;
   assign data_o       = data_q;

endmodule

// File: tb/tb_rgbled_ctrl.sv
// Directed bench for rgbled_ctrl: vector table for the main frame flow plus hand sequences for multi-cycle cases.
`timescale 1ns/1ps
module tb_rgbled_ctrl;

   localparam int Period = 100;

   logic        clk = 1'b0;
   logic        rst, set, refresh, off, ack, idle;
   logic [0:0]  set_idx;
   logic [23:0] set_rgb;
   logic        busy, go, valid, last;
   logic [23:0] data;

   logic        set3, refresh3, ack3;
   logic [1:0]  idx3;
   logic [23:0] rgb3;
   logic        busy3, go3, valid3, last3;
   logic [23:0] data3;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int frames;
   int first_k, second_k;
   logic pv;

   always #5 clk = ~clk;

   rgbled_ctrl #(.NumLeds(2), .RefreshPeriod(Period)) dut (
      .clk_i(clk), .rst_i(rst), .set_i(set), .set_idx_i(set_idx), .set_rgb_i(set_rgb),
      .refresh_i(refresh), .off_i(off), .busy_o(busy), .go_o(go), .data_o(data),
      .data_valid_o(valid), .data_last_o(last), .data_ack_i(ack), .idle_i(idle)
   );

   rgbled_ctrl #(.NumLeds(3), .RefreshPeriod(Period)) dut3 (
      .clk_i(clk), .rst_i(rst), .set_i(set3), .set_idx_i(idx3), .set_rgb_i(rgb3),
      .refresh_i(refresh3), .off_i(1'b0), .busy_o(busy3), .go_o(go3), .data_o(data3),
      .data_valid_o(valid3), .data_last_o(last3), .data_ack_i(ack3), .idle_i(1'b1)
   );

   typedef struct {
      logic        set;
      logic [0:0]  idx;
      logic [23:0] rgb;
      logic        refresh, off, ack, idle;
      logic        busy, valid, last;
      logic [23:0] data;
   } vec_t;

   vec_t tbl [27];

   function automatic vec_t mk(input logic s, input logic [0:0] i, input logic [23:0] c,
                               input logic r, input logic o, input logic a, input logic id,
                               input logic b, input logic v, input logic l, input logic [23:0] d);
      vec_t t;
      t.set = s; t.idx = i; t.rgb = c; t.refresh = r; t.off = o; t.ack = a; t.idle = id;
      t.busy = b; t.valid = v; t.last = l; t.data = d;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Simple driver model: acks every presented word, reports idle whenever nothing is presented.
   task automatic serve(input int cycles, output int nframes);
      nframes = 0;
      for (int k = 0; k < cycles; k++) begin
         ack  = valid;
         idle = !valid;
         if (valid && last) nframes++;
         step();
      end
      ack  = 1'b0;
      idle = 1'b1;
   endtask

   initial begin
      rst = 1'b1; set = 1'b0; set_idx = '0; set_rgb = '0; refresh = 1'b0; off = 1'b0;
      ack = 1'b0; idle = 1'b0;
      set3 = 1'b0; idx3 = '0; rgb3 = '0; refresh3 = 1'b0; ack3 = 1'b0;

      tbl[0]  = mk(1, 0, 24'hFF8000, 0, 0, 0, 1, 0, 0, 0, 24'h0);
      tbl[1]  = mk(1, 1, 24'h0000FF, 0, 0, 0, 1, 0, 0, 0, 24'h0);
      tbl[2]  = mk(0, 0, 24'h0,      1, 0, 0, 1, 0, 0, 0, 24'h0);
      tbl[3]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 0, 24'h80FF00);
      tbl[4]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 0, 24'h80FF00);
      tbl[5]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 0, 24'h80FF00);
      tbl[6]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 0, 24'h80FF00);
      tbl[7]  = mk(0, 0, 24'h0,      0, 0, 1, 0, 1, 1, 0, 24'h80FF00);
      tbl[8]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 1, 24'h0000FF);
      tbl[9]  = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 1, 24'h0000FF);
      tbl[10] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 1, 24'h0000FF);
      tbl[11] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 1, 1, 24'h0000FF);
      tbl[12] = mk(0, 0, 24'h0,      0, 0, 1, 0, 1, 1, 1, 24'h0000FF);
      tbl[13] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 0, 0, 24'h0);
      tbl[14] = mk(0, 0, 24'h0,      0, 0, 0, 1, 1, 0, 0, 24'h0);
      tbl[15] = mk(0, 0, 24'h0,      0, 0, 0, 1, 0, 0, 0, 24'h0);
      tbl[16] = mk(0, 0, 24'h0,      0, 0, 0, 1, 0, 0, 0, 24'h0);
      tbl[17] = mk(1, 1, 24'h123456, 0, 1, 0, 1, 0, 0, 0, 24'h0);
      tbl[18] = mk(0, 0, 24'h0,      0, 0, 1, 0, 1, 1, 0, 24'h000000);
      tbl[19] = mk(0, 0, 24'h0,      0, 0, 1, 0, 1, 1, 1, 24'h000000);
      tbl[20] = mk(0, 0, 24'h0,      0, 0, 0, 0, 1, 0, 0, 24'h0);
      tbl[21] = mk(0, 0, 24'h0,      0, 0, 0, 1, 1, 0, 0, 24'h0);
      tbl[22] = mk(1, 0, 24'h010203, 1, 0, 0, 1, 0, 0, 0, 24'h0);
      tbl[23] = mk(0, 0, 24'h0,      0, 0, 1, 0, 1, 1, 0, 24'h020103);
      tbl[24] = mk(0, 0, 24'h0,      0, 0, 1, 0, 1, 1, 1, 24'h000000);
      tbl[25] = mk(0, 0, 24'h0,      0, 0, 0, 1, 1, 0, 0, 24'h0);
      tbl[26] = mk(0, 0, 24'h0,      0, 0, 0, 1, 0, 0, 0, 24'h0);

      // Reset values after two reset cycles
      step(); step();
      chk("reset_out", {3'b0, busy, go, valid, last, data}, 32'h0);
      chk("reset_out3", {3'b0, busy3, go3, valid3, last3, data3}, 32'h0);
      rst = 1'b0;

`ifdef RGBLED_CTRL_AUTOREFRESH_EN
      rst = 1'b1; step(); step(); rst = 1'b0;
      idle = 1'b1;
      first_k = -1; second_k = -1; pv = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (valid && !pv) begin
            if (first_k < 0) first_k = k;
            else if (second_k < 0) second_k = k;
         end
         pv   = valid;
         ack  = valid;
         idle = !valid;
         step();
      end
      chk("auto_first", first_k, 101);
      chk("auto_second", second_k, 201);
`else
      // First frame after reset carries all-zero words
      refresh = 1'b1; idle = 1'b1; step();
      refresh = 1'b0; idle = 1'b0;
      chk("rst_w0", {6'b0, valid, last, data}, {6'b0, 1'b1, 1'b0, 24'h0});
      ack = 1'b1; step();
      chk("rst_w1", {6'b0, valid, last, data}, {6'b0, 1'b1, 1'b1, 24'h0});
      step();
      ack = 1'b0; idle = 1'b1; step();
      chk("rst_idle", {31'b0, busy}, 32'h0);

      for (int i = 0; i < 27; i++) begin
         set = tbl[i].set; set_idx = tbl[i].idx; set_rgb = tbl[i].rgb;
         refresh = tbl[i].refresh; off = tbl[i].off; ack = tbl[i].ack; idle = tbl[i].idle;
         #1;
         chk($sformatf("vec%0d", i),
             {4'b0, busy, go, valid, last, (tbl[i].valid ? data : 24'h0)},
             {4'b0, tbl[i].busy, tbl[i].valid, tbl[i].valid, tbl[i].last,
              (tbl[i].valid ? tbl[i].data : 24'h0)});
         step();
      end
      set = 1'b0; refresh = 1'b0; off = 1'b0; ack = 1'b0;

      // Three refreshes during SEND coalesce into one extra frame
      refresh = 1'b1; idle = 1'b1; step();
      refresh = 1'b0; idle = 1'b0;
      for (int p = 0; p < 3; p++) begin
         refresh = 1'b1; step();
         refresh = 1'b0; step();
      end
      chk("coal_hold", {7'b0, busy, data}, {7'b0, 1'b1, 24'h020103});
      serve(40, frames);
      chk("coal_frames", frames, 2);
      chk("coal_busy", {31'b0, busy}, 32'h0);

      // Reset while the last word is presented
      refresh = 1'b1; idle = 1'b1; step();
      refresh = 1'b0; idle = 1'b0; ack = 1'b1; step();
      ack = 1'b0;
      chk("midrst_pre", {6'b0, valid, last, data}, {6'b0, 1'b1, 1'b1, 24'h0});
      rst = 1'b1; step();
      chk("midrst_out", {3'b0, busy, go, valid, last, data}, 32'h0);
      rst = 1'b0;
      refresh = 1'b1; idle = 1'b1; step();
      refresh = 1'b0; idle = 1'b0;
      chk("midrst_w0", {6'b0, valid, last, data}, {6'b0, 1'b1, 1'b0, 24'h0});
      ack = 1'b1; step();
      chk("midrst_w1", {6'b0, valid, last, data}, {6'b0, 1'b1, 1'b1, 24'h0});
      serve(10, frames);

      // Three-LED chain: out-of-range index is ignored
      set3 = 1'b1; idx3 = 2'd3; rgb3 = 24'hABCDEF; step();
      idx3 = 2'd2; rgb3 = 24'h112233; step();
      set3 = 1'b0; refresh3 = 1'b1; step();
      refresh3 = 1'b0;
      chk("n3_w0", {6'b0, valid3, last3, data3}, {6'b0, 1'b1, 1'b0, 24'h0});
      ack3 = 1'b1; step();
      chk("n3_w1", {6'b0, valid3, last3, data3}, {6'b0, 1'b1, 1'b0, 24'h0});
      step();
      chk("n3_w2", {6'b0, valid3, last3, data3}, {6'b0, 1'b1, 1'b1, 24'h221133});
      step();
      ack3 = 1'b0;
      chk("n3_end", {30'b0, valid3, busy3}, {30'b0, 1'b0, 1'b1});

      // No autorefresh in the default build
      serve(300, frames);
      chk("no_auto", frames, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
